// File: rtl/alarm_controller.sv
// Intruder alarm sequencer: exit/entry delays, instant zones, timed siren and
// sticky zone capture. All timing advances on the one-cycle tick strobe.
module alarm_controller #(
    parameter int unsigned EXIT_DLY   = 10,
    parameter int unsigned ENTRY_DLY  = 8,
    parameter int unsigned SIREN_TIME = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [4:0] opening,
    input  logic       arm_req,
    input  logic       disarm_req,
    output logic [2:0] state,
    output logic [4:0] alarm_zones,
    output logic       siren,
    output logic [3:0] countdown,
    output logic       arm_fail
);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    localparam logic [7:0] EXIT_LD  = 8'(EXIT_DLY);
    localparam logic [7:0] ENTRY_LD = 8'(ENTRY_DLY);
    localparam logic [7:0] SIREN_LD = 8'(SIREN_TIME);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] zones_q, zones_d;
    logic       arm_fail_q, arm_fail_d;

    // NOTE: every register, including the sticky zone record, is in the async
    // reset so that reset silences the siren without needing a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_DISARMED;
            cnt_q      <= 8'd0;
            zones_q    <= 5'd0;
            arm_fail_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state registers update from the same
            // pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zones_q    <= zones_d;
            arm_fail_q <= arm_fail_d;
        end
    end

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latches infer.
        state_d    = state_q;
        cnt_d      = cnt_q;
        zones_d    = zones_q;
        arm_fail_d = 1'b0;

        if (state_q == ST_DISARMED) begin
            // A disarm in DISARMED outranks a coincident arm and does nothing.
            if (arm_req && !disarm_req) begin
                if (opening == 5'd0) begin
                    state_d = ST_EXIT;
                    cnt_d   = EXIT_LD;
                    zones_d = 5'd0;
                end else begin
                    arm_fail_d = 1'b1;
                end
            end
        end else if (disarm_req) begin
            state_d = ST_DISARMED;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                ST_EXIT: begin
                    if (tick) begin
                        if (cnt_q <= 8'd1) begin
                            state_d = ST_ARMED;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (opening[4:1] != 4'd0) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LD;
                        zones_d = zones_q | opening;
                    end else if (opening[0]) begin
                        state_d    = ST_ENTRY;
                        cnt_d      = ENTRY_LD;
                        zones_d[0] = 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (opening[4:1] != 4'd0) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LD;
                        zones_d = zones_q | {opening[4:1], 1'b0};
                    end else if (tick) begin
                        if (cnt_q <= 8'd1) begin
                            state_d = ST_ALARM;
                            cnt_d   = SIREN_LD;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                ST_ALARM: begin
                    zones_d = zones_q | opening;
                    if (tick && cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign state       = state_q;
    assign alarm_zones = zones_q;
    assign arm_fail    = arm_fail_q;
    assign siren       = (state_q == ST_ALARM) && (cnt_q != 8'd0);

    always_comb begin
        countdown = 4'd0;
        if (state_q == ST_EXIT || state_q == ST_ENTRY || state_q == ST_ALARM) begin
            countdown = (cnt_q > 8'd15) ? 4'd15 : cnt_q[3:0];
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with default delays (10/8/20 ticks).
module tb_alarm_controller;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic [4:0] opening;
    logic       arm_req;
    logic       disarm_req;
    logic [2:0] state;
    logic [4:0] alarm_zones;
    logic       siren;
    logic [3:0] countdown;
    logic       arm_fail;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .opening     (opening),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .state       (state),
        .alarm_zones (alarm_zones),
        .siren       (siren),
        .countdown   (countdown),
        .arm_fail    (arm_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step(input logic tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_req = 1'b1;
        step(1'b0);
        arm_req = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm_req = 1'b1;
        step(1'b0);
        disarm_req = 1'b0;
    endtask

    task automatic go_armed();
        pulse_arm();
        for (int i = 0; i < 10; i++) step(1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b0; opening = 5'd0; arm_req = 1'b0; disarm_req = 1'b0;
        #2;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
        n_checks++; if (siren !== 1'b0) begin n_fail++; $display("FAIL rst_siren: got %0b want 0", siren); end
        n_checks++; if (alarm_zones !== 5'd0) begin n_fail++; $display("FAIL rst_zones: got %b want 00000", alarm_zones); end
        n_checks++; if (countdown !== 4'd0) begin n_fail++; $display("FAIL rst_countdown: got %0d want 0", countdown); end
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL rst_arm_fail: got %0b want 0", arm_fail); end
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exit();
        // Arm with a coincident tick: the loaded 10 must not be decremented.
        arm_req = 1'b1;
        step(1'b1);
        arm_req = 1'b0;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL exit_enter: got %0d want 1", state); end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            n_checks++; if (countdown !== 4'(10 - i)) begin n_fail++; $display("FAIL exit_countdown[%0d]: got %0d want %0d", i, countdown, 10 - i); end
            n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL exit_state[%0d]: got %0d want 1", i, state); end
            step(1'b1);
        end
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL exit_armed: got %0d want 2", state); end
        n_checks++; if (countdown !== 4'd0) begin n_fail++; $display("FAIL armed_countdown: got %0d want 0", countdown); end
        n_checks++; if (alarm_zones !== 5'd0) begin n_fail++; $display("FAIL armed_zones: got %b want 00000", alarm_zones); end
        // arm_req while armed is ignored silently.
        pulse_arm();
        n_checks++; if (state !== 3'd2 || arm_fail !== 1'b0) begin n_fail++; $display("FAIL armed_rearm: got state %0d arm_fail %0b want 2/0", state, arm_fail); end
    endtask

    task automatic test_entry_alarm();
        opening = 5'b00001;
        step(1'b0);
        opening = 5'b00000;
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL entry_enter: got %0d want 3", state); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (countdown !== 4'(8 - i)) begin n_fail++; $display("FAIL entry_countdown[%0d]: got %0d want %0d", i, countdown, 8 - i); end
            step(1'b1);
        end
        n_checks++; if (state !== 3'd4 || siren !== 1'b1) begin n_fail++; $display("FAIL entry_timeout: got state %0d siren %0b want 4/1", state, siren); end
        n_checks++; if (alarm_zones !== 5'b00001) begin n_fail++; $display("FAIL entry_zones: got %b want 00001", alarm_zones); end
        n_checks++; if (countdown !== 4'd15) begin n_fail++; $display("FAIL alarm_countdown_sat: got %0d want 15", countdown); end
        for (int i = 0; i < 19; i++) step(1'b1);
        n_checks++; if (siren !== 1'b1 || countdown !== 4'd1) begin n_fail++; $display("FAIL siren_19: got siren %0b countdown %0d want 1/1", siren, countdown); end
        step(1'b1);
        n_checks++; if (siren !== 1'b0 || state !== 3'd4) begin n_fail++; $display("FAIL siren_20: got siren %0b state %0d want 0/4", siren, state); end
        step(1'b1);
        n_checks++; if (countdown !== 4'd0 || state !== 3'd4) begin n_fail++; $display("FAIL alarm_floor: got countdown %0d state %0d want 0/4", countdown, state); end
        opening = 5'b00100;
        step(1'b0);
        opening = 5'b00000;
        n_checks++; if (alarm_zones !== 5'b00101) begin n_fail++; $display("FAIL alarm_or: got %b want 00101", alarm_zones); end
        pulse_disarm();
        n_checks++; if (state !== 3'd0 || siren !== 1'b0) begin n_fail++; $display("FAIL alarm_disarm: got state %0d siren %0b want 0/0", state, siren); end
        n_checks++; if (alarm_zones !== 5'b00101) begin n_fail++; $display("FAIL zones_retained: got %b want 00101", alarm_zones); end
    endtask

    task automatic test_entry_disarm();
        go_armed();
        n_checks++; if (state !== 3'd2 || alarm_zones !== 5'd0) begin n_fail++; $display("FAIL rearm_clears: got state %0d zones %b want 2/00000", state, alarm_zones); end
        opening = 5'b00001;
        step(1'b0);
        opening = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_checks++; if (siren !== 1'b0 || state !== 3'd3) begin n_fail++; $display("FAIL entry_quiet[%0d]: got siren %0b state %0d want 0/3", i, siren, state); end
        end
        n_checks++; if (countdown !== 4'd5) begin n_fail++; $display("FAIL entry_after3: got %0d want 5", countdown); end
        pulse_disarm();
        n_checks++; if (state !== 3'd0 || siren !== 1'b0 || countdown !== 4'd0) begin n_fail++; $display("FAIL entry_disarm: got state %0d siren %0b countdown %0d want 0/0/0", state, siren, countdown); end
        n_checks++; if (alarm_zones !== 5'b00001) begin n_fail++; $display("FAIL entry_zones_kept: got %b want 00001", alarm_zones); end
    endtask

    task automatic test_instant_and_reset();
        go_armed();
        opening = 5'b00001;
        step(1'b0);
        // Instant zone in ENTRY with a coincident tick: cnt loads 20 undecremented.
        opening = 5'b10001;
        step(1'b1);
        opening = 5'b00000;
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL instant_state: got %0d want 4", state); end
        n_checks++; if (alarm_zones !== 5'b10001) begin n_fail++; $display("FAIL instant_zones: got %b want 10001", alarm_zones); end
        n_checks++; if (countdown !== 4'd15 || siren !== 1'b1) begin n_fail++; $display("FAIL instant_countdown: got %0d siren %0b want 15/1", countdown, siren); end
        for (int i = 0; i < 5; i++) step(1'b1);
        n_checks++; if (countdown !== 4'd15) begin n_fail++; $display("FAIL instant_5ticks: got %0d want 15", countdown); end
        step(1'b1);
        n_checks++; if (countdown !== 4'd14) begin n_fail++; $display("FAIL instant_6ticks: got %0d want 14", countdown); end
        // Asynchronous reset mid-alarm, checked well before the next edge.
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (siren !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL async_reset: got siren %0b state %0d want 0/0", siren, state); end
        n_checks++; if (alarm_zones !== 5'd0 || countdown !== 4'd0) begin n_fail++; $display("FAIL async_reset_regs: got zones %b countdown %0d want 00000/0", alarm_zones, countdown); end
        #2 reset_n = 1'b1;
        arm_req = 1'b1;
        @(posedge clk); #1;
        arm_req = 1'b0;
        n_checks++; if (state !== 3'd1 || countdown !== 4'd10) begin n_fail++; $display("FAIL arm_after_reset: got state %0d countdown %0d want 1/10", state, countdown); end
    endtask

    task automatic test_arm_fail();
        pulse_disarm();
        opening = 5'b00100;
        pulse_arm();
        n_checks++; if (state !== 3'd0 || arm_fail !== 1'b1) begin n_fail++; $display("FAIL arm_fail_pulse: got state %0d arm_fail %0b want 0/1", state, arm_fail); end
        step(1'b0);
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL arm_fail_width: got %0b want 0", arm_fail); end
        opening = 5'b00000;
        pulse_arm();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL arm_retry: got %0d want 1", state); end
        arm_req = 1'b1; disarm_req = 1'b1;
        step(1'b1);
        arm_req = 1'b0; disarm_req = 1'b0;
        n_checks++; if (state !== 3'd0 || arm_fail !== 1'b0 || countdown !== 4'd0) begin n_fail++; $display("FAIL arm_disarm_both: got state %0d arm_fail %0b countdown %0d want 0/0/0", state, arm_fail, countdown); end
    endtask

    initial begin
        test_reset();
        test_exit();
        test_entry_alarm();
        test_entry_disarm();
        test_instant_and_reset();
        test_arm_fail();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have parameter EXIT_DLY, default 10, the exit delay in ticks (legal range 1..255).
REQ-002 The block SHALL have parameter ENTRY_DLY, default 8, the entry delay in ticks (legal range 1..255).
REQ-003 The block SHALL have parameter SIREN_TIME, default 20, the siren duration in ticks (legal range 1..255).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 tick  input  1  one-cycle time-base strobe (nominally 1 Hz); all delay counters advance only on tick.
REQ-007 opening  input  5  door/window status, 1 = open; bit 0 = entry door (delayed zone), bits 4:1 = instant zones.
REQ-008 arm_req  input  1  one-cycle arm request.
REQ-009 disarm_req  input  1  one-cycle disarm request (valid code already checked upstream).
REQ-010 state  output  3  current state: 0 DISARMED, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM.
REQ-011 alarm_zones  output  5  sticky record of zones that caused entry/alarm, bit-aligned with opening.
REQ-012 siren  output  1  siren drive, 1 = sounding.
REQ-013 countdown  output  4  remaining ticks for the display driver, saturated at 15.
REQ-014 arm_fail  output  1  one-cycle pulse, arm request refused.

Function
REQ-015 The block SHALL implement a 5-state FSM with an 8-bit down-counter `cnt`, both registered.
REQ-016 DISARMED: arm_req with opening==0 SHALL go to EXIT, load cnt=EXIT_DLY, and clear alarm_zones; arm_req with any opening bit set SHALL stay DISARMED and pulse arm_fail for exactly one cycle on the following edge.
REQ-017 EXIT: each tick SHALL decrement cnt; the tick on which cnt==1 SHALL move to ARMED with cnt=0; opening is ignored in EXIT.
REQ-018 ARMED: opening[4:1]!=0 SHALL move to ALARM, load cnt=SIREN_TIME, and OR opening into alarm_zones; otherwise opening[0]==1 SHALL move to ENTRY, load cnt=ENTRY_DLY, and set alarm_zones[0].
REQ-019 ENTRY: tick SHALL decrement cnt; the tick on which cnt==1 SHALL move to ALARM with cnt=SIREN_TIME; opening[4:1]!=0 SHALL move to ALARM immediately, OR those bits into alarm_zones, and load cnt=SIREN_TIME.
REQ-020 ALARM: siren SHALL be 1 while cnt!=0; each tick SHALL decrement cnt to a floor of 0; at cnt==0 siren SHALL drop but the state SHALL remain ALARM until disarm; newly opened zones SHALL keep ORing into alarm_zones.
REQ-021 disarm_req in EXIT, ARMED, ENTRY or ALARM SHALL move to DISARMED next edge with cnt=0 and siren=0; alarm_zones SHALL be retained for review until the next successful arm.
REQ-022 Priority SHALL be disarm_req > arm_req > zone events > tick; arm_req outside DISARMED SHALL be ignored with no arm_fail.
REQ-023 A cycle that takes a state transition and loads cnt SHALL ignore a coincident tick (loaded value not decremented).
REQ-024 countdown SHALL equal min(cnt,15) in EXIT, ENTRY and ALARM, and 0 in DISARMED and ARMED.
REQ-025 All outputs SHALL be driven directly from registers or decoded from state/cnt with no combinational path from inputs.

Reset
REQ-026 reset_n low SHALL asynchronously force state=DISARMED, cnt=0, alarm_zones=0, siren=0, arm_fail=0, countdown=0.
REQ-027 Reset asserted mid-operation (including ALARM with siren=1) SHALL silence siren immediately without waiting for clk.
REQ-028 After reset_n rises the FSM SHALL accept arm_req on the first clock edge.

Verification
REQ-029 Defaults, opening=0, arm_req, 10 ticks -> state 1 with countdown 10..1, state 2 after 10th tick, alarm_zones=0.
REQ-030 ARMED, opening=5'b00001, 8 ticks, no disarm -> state 3, countdown 8..1, then state 4 with siren=1, alarm_zones=5'b00001; after 20 more ticks siren=0, state stays 4.
REQ-031 ARMED, opening=5'b00001, disarm_req after 3 ticks -> state 0, siren never 1, alarm_zones=5'b00001 retained.
REQ-032 ENTRY, opening=5'b10001 -> state 4 next edge, alarm_zones=5'b10001, countdown=15 (cnt 20).
REQ-033 DISARMED, opening=5'b00100, arm_req -> state stays 0, arm_fail high exactly one cycle; arm_req and disarm_req together in EXIT -> state 0.
REQ-034 ALARM with siren=1, reset_n pulsed low between clock edges -> siren=0 and state=0 before next clk edge.
